// File: rtl/store_narrow_buffer_if.sv
// Store request / data-memory write bus for store_narrow_buffer.
// The master side issues stores and consumes the queued writes; the slave side is the buffer.
interface store_narrow_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  StoreOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        output StoreOp,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_addr,
        input  out_wdata,
        input  out_be
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        input  StoreOp,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_addr,
        output out_wdata,
        output out_be
    );
endinterface

// File: rtl/store_narrow_buffer.sv
// Narrows/aligns store data, builds byte enables and queues writes toward the DM port.
// Optional misalignment trap enabled by defining STORE_ALIGN_CHECK_EN.
module store_narrow_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    store_narrow_buffer_if.slave bus
`ifdef STORE_ALIGN_CHECK_EN
    ,
    output logic        align_err,
    output logic [31:0] err_addr
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] OpSw  = 2'b00;
    localparam logic [1:0] OpSh  = 2'b01;
    localparam logic [1:0] OpSb  = 2'b10;

    logic [31:0]     addr_q  [DEPTH];
    logic [31:0]     wdata_q [DEPTH];
    logic [3:0]      be_q    [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic [1:0]  lane;
    logic [31:0] n_wdata;
    logic [3:0]  n_be;
    logic        op_ok;
    logic        accept;
    logic        push;
    logic        pop;

    assign lane = bus.in_addr[1:0];

    always_comb begin
        n_wdata = '0;
        n_be    = '0;
        op_ok   = 1'b0;
        case (bus.StoreOp)
            OpSw: begin
                n_wdata = bus.in_data;
                n_be    = 4'b1111;
                op_ok   = 1'b1;
            end
            OpSh: begin
                n_wdata = {2{bus.in_data[15:0]}};
                n_be    = lane[1] ? 4'b1100 : 4'b0011;
                op_ok   = 1'b1;
            end
            OpSb: begin
                n_wdata = {4{bus.in_data[7:0]}};
                n_be    = 4'b0001 << lane;
                op_ok   = 1'b1;
            end
            default: begin
                // Reserved op: handshake still completes, nothing queued.
                op_ok = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = (count_q < CntW'(DEPTH));
    assign accept       = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_valid & bus.out_ready;

`ifdef STORE_ALIGN_CHECK_EN
    logic misalign;

    always_comb begin
        misalign = 1'b0;
        case (bus.StoreOp)
            OpSw:    misalign = (lane != 2'b00);
            OpSh:    misalign = lane[0];
            default: misalign = 1'b0;
        endcase
    end

    assign push = accept & op_ok & ~misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
            err_addr  <= '0;
        end else begin
            align_err <= accept & misalign;
            if (accept & misalign) begin
                err_addr <= bus.in_addr;
            end
        end
    end
`else
    assign push = accept & op_ok;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                addr_q[wr_ptr_q]  <= {bus.in_addr[31:2], 2'b00};
                wdata_q[wr_ptr_q] <= n_wdata;
                be_q[wr_ptr_q]    <= n_be;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Outputs are zero whenever the queue is empty so stale slots never leak out.
    assign bus.out_valid = (count_q != '0);
    assign bus.out_addr  = bus.out_valid ? addr_q[rd_ptr_q]  : '0;
    assign bus.out_wdata = bus.out_valid ? wdata_q[rd_ptr_q] : '0;
    assign bus.out_be    = bus.out_valid ? be_q[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed self-checking bench for store_narrow_buffer (DEPTH=2).
// Align-trap checks follow STORE_ALIGN_CHECK_EN, matching the RTL build.
module tb_store_narrow_buffer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    store_narrow_buffer_if sif ();

`ifdef STORE_ALIGN_CHECK_EN
    logic        align_err;
    logic [31:0] err_addr;
`endif

    store_narrow_buffer #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (sif.slave)
`ifdef STORE_ALIGN_CHECK_EN
        ,
        .align_err (align_err),
        .err_addr  (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.in_valid = 1'b0;
        sif.in_addr  = '0;
        sif.in_data  = '0;
        sif.StoreOp  = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        sif.out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        tests++;
        if (sif.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got=%b exp=0", sif.out_valid);
        end
        tests++;
        if (sif.out_be !== 4'b0000) begin
            fails++; $display("FAIL reset_out_be got=%b exp=0000", sif.out_be);
        end
        tests++;
        if (sif.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got=%b exp=1", sif.in_ready);
        end
        tests++;
        if (sif.out_addr !== 32'h0 || sif.out_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_out_bus got addr=%h wdata=%h exp 0/0", sif.out_addr, sif.out_wdata);
        end
    endtask

    task automatic test_narrowing();
        logic [1:0]  ops   [5] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
        logic [31:0] addrs [5] = '{32'h1003, 32'h2002, 32'h3000, 32'h5001, 32'h5000};
        logic [31:0] datas [5] = '{32'h123456AB, 32'hFFFF8001, 32'hDEADBEEF, 32'h000000C3,
                                   32'h0000BEEF};
        logic [31:0] e_addr[5] = '{32'h1000, 32'h2000, 32'h3000, 32'h5000, 32'h5000};
        logic [31:0] e_wd  [5] = '{32'hABABABAB, 32'h80018001, 32'hDEADBEEF, 32'hC3C3C3C3,
                                   32'hBEEFBEEF};
        logic [3:0]  e_be  [5] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0011};
        sif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sif.in_valid = 1'b1;
            sif.StoreOp  = ops[i];
            sif.in_addr  = addrs[i];
            sif.in_data  = datas[i];
            step();
            idle_inputs();
            tests++;
            if (sif.out_valid !== 1'b1 || sif.out_addr !== e_addr[i] ||
                sif.out_wdata !== e_wd[i] || sif.out_be !== e_be[i]) begin
                fails++;
                $display("FAIL narrow[%0d] got v=%b addr=%h wd=%h be=%b exp v=1 addr=%h wd=%h be=%b",
                         i, sif.out_valid, sif.out_addr, sif.out_wdata, sif.out_be,
                         e_addr[i], e_wd[i], e_be[i]);
            end
            step();
            tests++;
            if (sif.out_valid !== 1'b0) begin
                fails++; $display("FAIL narrow_pop[%0d] out_valid got=%b exp=0", i, sif.out_valid);
            end
        end
    endtask

    task automatic test_reserved();
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        sif.StoreOp   = 2'b11;
        sif.in_addr   = 32'h7000;
        sif.in_data   = 32'h55555555;
        tests++;
        if (sif.in_ready !== 1'b1) begin
            fails++; $display("FAIL reserved_in_ready got=%b exp=1", sif.in_ready);
        end
        step();
        idle_inputs();
        tests++;
        if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reserved_not_queued got v=%b rdy=%b exp v=0 rdy=1",
                     sif.out_valid, sif.in_ready);
        end
    endtask

    task automatic test_backpressure();
        sif.out_ready = 1'b0;
        sif.StoreOp   = 2'b00;
        sif.in_valid  = 1'b1;
        sif.in_addr   = 32'h100; sif.in_data = 32'h1;
        step();
        sif.in_addr   = 32'h104; sif.in_data = 32'h2;
        step();
        sif.in_addr   = 32'h108; sif.in_data = 32'h3;
        #1;
        tests++;
        if (sif.in_ready !== 1'b0 || sif.out_addr !== 32'h100 || sif.out_wdata !== 32'h1) begin
            fails++;
            $display("FAIL bp_full got rdy=%b addr=%h wd=%h exp rdy=0 addr=00000100 wd=00000001",
                     sif.in_ready, sif.out_addr, sif.out_wdata);
        end
        step();
        tests++;
        if (sif.in_ready !== 1'b0 || sif.out_addr !== 32'h100) begin
            fails++;
            $display("FAIL bp_hold got rdy=%b addr=%h exp rdy=0 addr=00000100",
                     sif.in_ready, sif.out_addr);
        end
        // Popping does not open in_ready in the same cycle.
        sif.out_ready = 1'b1;
        #1;
        tests++;
        if (sif.in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_ready_indep got=%b exp=0", sif.in_ready);
        end
        step();
        tests++;
        if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b1 || sif.out_addr !== 32'h104 ||
            sif.out_wdata !== 32'h2) begin
            fails++;
            $display("FAIL bp_second got rdy=%b v=%b addr=%h wd=%h exp rdy=1 v=1 addr=00000104 wd=2",
                     sif.in_ready, sif.out_valid, sif.out_addr, sif.out_wdata);
        end
        step();
        idle_inputs();
        tests++;
        if (sif.out_valid !== 1'b1 || sif.out_addr !== 32'h108 || sif.out_wdata !== 32'h3) begin
            fails++;
            $display("FAIL bp_third got v=%b addr=%h wd=%h exp v=1 addr=00000108 wd=3",
                     sif.out_valid, sif.out_addr, sif.out_wdata);
        end
        step();
        tests++;
        if (sif.out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drained out_valid got=%b exp=0", sif.out_valid);
        end
    endtask

    task automatic test_align();
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        sif.StoreOp   = 2'b00;
        sif.in_addr   = 32'h4001;
        sif.in_data   = 32'h11223344;
        step();
        idle_inputs();
`ifdef STORE_ALIGN_CHECK_EN
        tests++;
        if (align_err !== 1'b1 || err_addr !== 32'h4001 || sif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL align_trap got err=%b eaddr=%h v=%b exp err=1 eaddr=00004001 v=0",
                     align_err, err_addr, sif.out_valid);
        end
        step();
        tests++;
        if (align_err !== 1'b0 || err_addr !== 32'h4001 || sif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL align_pulse got err=%b eaddr=%h v=%b exp err=0 eaddr=00004001 v=0",
                     align_err, err_addr, sif.out_valid);
        end
`else
        tests++;
        if (sif.out_valid !== 1'b1 || sif.out_addr !== 32'h4000 || sif.out_be !== 4'b1111 ||
            sif.out_wdata !== 32'h11223344) begin
            fails++;
            $display("FAIL align_off got v=%b addr=%h be=%b wd=%h exp v=1 addr=00004000 be=1111",
                     sif.out_valid, sif.out_addr, sif.out_be, sif.out_wdata);
        end
        step();
`endif
    endtask

    task automatic test_reset_midflight();
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        sif.StoreOp   = 2'b10;
        sif.in_addr   = 32'h8000; sif.in_data = 32'hAA;
        step();
        sif.in_addr   = 32'h8004; sif.in_data = 32'hBB;
        step();
        idle_inputs();
        tests++;
        if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_full got v=%b rdy=%b exp v=1 rdy=0", sif.out_valid, sif.in_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1 || sif.out_be !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_flush got v=%b rdy=%b be=%b exp v=0 rdy=1 be=0000",
                     sif.out_valid, sif.in_ready, sif.out_be);
        end
        sif.out_ready = 1'b1;
        step();
        step();
        tests++;
        if (sif.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_no_emit out_valid got=%b exp=0", sif.out_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        sif.out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_narrowing();
        test_reserved();
        test_backpressure();
        test_align();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
